// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debounce controller.
//   btn_state_t : per-channel debounce FSM state
//   cnt_w()     : bit width needed to hold values 0..n
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Width of a counter that must represent 0..n inclusive (never below 1).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce FSM with its debounce / hold counters.
//   clk, rst : clock, async active-low reset
//   s        : synchronized button level
//   tick     : one-cycle debounce pacing strobe
//   level    : debounced level (registered)
//   press    : one-cycle pulse on accepted press
//   rel      : one-cycle pulse on accepted release
//   lng      : one-cycle pulse once per press when the hold reaches LONG_TICKS
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DB_TICKS   = 20,
    parameter int LONG_TICKS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic tick,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng
);

    localparam int DBW = cnt_w(DB_TICKS);
    localparam int HW  = cnt_w(LONG_TICKS);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_TICKS - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_TICKS - 1);

    btn_state_t     state, state_n;
    logic [DBW-1:0] db_cnt, db_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic           long_done, long_done_n;
    logic           level_n, press_n, rel_n, lng_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            lng       <= 1'b0;
        end else begin
            state     <= state_n;
            db_cnt    <= db_n;
            hold_cnt  <= hold_n;
            long_done <= long_done_n;
            level     <= level_n;
            press     <= press_n;
            rel       <= rel_n;
            lng       <= lng_n;
        end
    end

    // A change of s always takes priority over a tick in the same cycle,
    // so a qualifying tick coinciding with a bounce never accepts.
    always_comb begin
        state_n     = state;
        db_n        = db_cnt;
        hold_n      = hold_cnt;
        long_done_n = long_done;
        press_n     = 1'b0;
        rel_n       = 1'b0;
        lng_n       = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    db_n    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (db_cnt == DB_LAST) begin
                        state_n     = PRESSED;
                        hold_n      = '0;
                        long_done_n = 1'b0;
                        press_n     = 1'b1;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = RELEASE_WAIT;
                    db_n    = '0;
                end else if (tick && !long_done) begin
                    // hold_cnt tops out at LONG_TICKS because long_done
                    // stops further counting.
                    hold_n = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        long_done_n = 1'b1;
                        lng_n       = 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                // hold_cnt / long_done are untouched here so a bounce back
                // to PRESSED resumes the long-press count where it stopped.
                if (s) begin
                    state_n = PRESSED;
                end else if (tick) begin
                    if (db_cnt == DB_LAST) begin
                        state_n = IDLE;
                        rel_n   = 1'b1;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        level_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    end

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Multi-channel push-button controller: 3-flop synchronizer per button,
// shared tick prescaler, and one debounce FSM per channel.
//   clk       : system clock
//   rst       : async active-low reset
//   btn_i     : raw asynchronous buttons, active-high
//   level_o   : debounced levels
//   press_o   : one-cycle press pulses
//   release_o : one-cycle release pulses
//   long_o    : one-cycle long-press pulses
module btn_debounce_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int DB_TICKS   = 20,
    parameter int LONG_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o
);

    localparam int PW = cnt_w(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [N_BTN-1:0] s1, s2, s;

    // Free-running prescaler shared by all channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
        else                         pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s  <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
            s  <= s2;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_channel #(
            .DB_TICKS   (DB_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .s     (s[g]),
            .tick  (tick),
            .level (level_o[g]),
            .press (press_o[g]),
            .rel   (release_o[g]),
            .lng   (long_o[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
module tb_btn_debounce_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_i = 4'hF;
    logic [3:0] level_o, press_o, release_o, long_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btn_debounce_ctrl #(
        .N_BTN      (4),
        .TICK_DIV   (4),
        .DB_TICKS   (3),
        .LONG_TICKS (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_i),
        .level_o   (level_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    // Edge index: after posedge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled shortly after each rising edge.
    int n_press[4];
    int n_rel[4];
    int n_long[4];
    int press_at[4];
    int rel_at[4];
    int long_at[4];
    bit pair_seen = 1'b0;

    always @(posedge clk) begin
        #2;
        for (int c = 0; c < 4; c++) begin
            if (press_o[c])   begin n_press[c]++; press_at[c] = cyc; end
            if (release_o[c]) begin n_rel[c]++;   rel_at[c]   = cyc; end
            if (long_o[c])    begin n_long[c]++;  long_at[c]  = cyc; end
        end
        if (press_o == 4'b1001) pair_seen = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // lat_kind: 0 none, 1 press latency, 2 release latency, 3 long-after-press
    typedef struct {
        logic [3:0] btn;
        int         cycles;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] lvl;
        int         lat_kind;
        int         lat_ch;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];

    initial begin
        vec_t e;
        int   drv, ch, tot_p, tot_r, tot_l, p0, base_r, base_l, base_p, drops;
        int   b_press[4];
        int   b_rel[4];
        int   b_long[4];
        logic [3:0] m_p, m_r, m_l;

        vecs[0] = '{4'b0000, 100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        vecs[1] = '{4'b0001,  20, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0};
        vecs[2] = '{4'b0000,  20, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2, 0};
        vecs[3] = '{4'b0010,   6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        vecs[4] = '{4'b0000,  20, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        vecs[5] = '{4'b0100,  80, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 3, 2};
        vecs[6] = '{4'b0000,  20, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 2, 2};
        vecs[7] = '{4'b1001,  20, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 1, 3};

        // Reset held with all buttons high: everything stays quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("reset outputs %0d", i),
                {level_o, press_o, release_o, long_o}, 0);
        end
        btn_i = 4'h0;
        @(negedge clk);
        rst = 1'b1;

        // Table-driven segments through a scoreboard queue.
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) begin
                b_press[c] = n_press[c];
                b_rel[c]   = n_rel[c];
                b_long[c]  = n_long[c];
            end
            drv   = cyc;
            btn_i = vecs[i].btn;
            exp_q.push_back(vecs[i]);
            repeat (vecs[i].cycles) @(negedge clk);
            e = exp_q.pop_front();
            tot_p = 0; tot_r = 0; tot_l = 0;
            for (int c = 0; c < 4; c++) begin
                m_p[c] = (n_press[c] != b_press[c]);
                m_r[c] = (n_rel[c]   != b_rel[c]);
                m_l[c] = (n_long[c]  != b_long[c]);
                tot_p += n_press[c] - b_press[c];
                tot_r += n_rel[c]   - b_rel[c];
                tot_l += n_long[c]  - b_long[c];
            end
            chk($sformatf("seg%0d press mask", i),   m_p, e.press);
            chk($sformatf("seg%0d release mask", i), m_r, e.rel);
            chk($sformatf("seg%0d long mask", i),    m_l, e.lng);
            chk($sformatf("seg%0d press count", i),   tot_p, $countones(e.press));
            chk($sformatf("seg%0d release count", i), tot_r, $countones(e.rel));
            chk($sformatf("seg%0d long count", i),    tot_l, $countones(e.lng));
            chk($sformatf("seg%0d level", i),         level_o, e.lvl);
            ch = e.lat_ch;
            case (e.lat_kind)
                1: chk_rng($sformatf("seg%0d press latency", i), press_at[ch] - drv, 13, 16);
                2: chk_rng($sformatf("seg%0d release latency", i), rel_at[ch] - drv, 13, 16);
                3: chk($sformatf("seg%0d long after press", i), long_at[ch] - press_at[ch], 20);
                default: ;
            endcase
        end
        chk("ch0+ch3 press same cycle", pair_seen, 1);

        // Reset while ch0/ch3 are pressed: immediate clear, no release.
        base_r = n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3];
        rst = 1'b0;
        #1;
        chk("level on async reset", level_o, 0);
        chk("outputs on async reset", {press_o, release_o, long_o}, 0);
        repeat (3) @(negedge clk);
        chk("level held in reset", level_o, 0);
        btn_i = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("no release after reset", n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3] - base_r, 0);
        chk("level after reset", level_o, 0);

        // Release bounce: 3-cycle drop while pressed is absorbed; the long
        // pulse slips by exactly one tick period.
        base_p = n_press[0];
        btn_i  = 4'b0001;
        for (int t = 0; t < 40 && n_press[0] == base_p; t++) @(negedge clk);
        chk("bounce: press seen", n_press[0] - base_p, 1);
        p0     = press_at[0];
        base_r = n_rel[0];
        base_l = n_long[0];
        repeat (5) @(negedge clk);
        btn_i = 4'b0000;
        repeat (3) @(negedge clk);
        btn_i = 4'b0001;
        drops = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!level_o[0]) drops++;
        end
        chk("bounce: level stays high", drops, 0);
        chk("bounce: no release", n_rel[0] - base_r, 0);
        chk("bounce: one long", n_long[0] - base_l, 1);
        chk("bounce: long after press", long_at[0] - p0, 24);
        btn_i = 4'b0000;
        repeat (30) @(negedge clk);
        chk("bounce: final release", n_rel[0] - base_r, 1);
        chk("bounce: final level", level_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce_ctrl.md
Name: btn_debounce_ctrl

Overview:
- Multi-channel push-button controller.
- Each raw asynchronous button bit passes through a 3-flop synchronizer, then a per-channel debounce FSM.
- The FSM is paced by a shared millisecond-scale tick prescaler.
- Outputs per channel: clean level, press/release one-cycle pulses, and a long-press pulse.
- Sits between board button pins and the user-logic/FSM layer; downstream logic never sees raw button bits.

Parameters:
- N_BTN, 4, number of independent button channels.
- TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be >= 2.
- DB_TICKS, 20, consecutive stable ticks needed to accept a press or a release; must be >= 1.
- LONG_TICKS, 1000, ticks in the pressed state before a long-press pulse; must be > DB_TICKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_i  in  N_BTN  raw asynchronous button inputs, active-high.
- level_o  out  N_BTN  debounced button level.
- press_o  out  N_BTN  one-cycle pulse on accepted press.
- release_o  out  N_BTN  one-cycle pulse on accepted release.
- long_o  out  N_BTN  one-cycle pulse once per press when the hold reaches LONG_TICKS.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-low.
  - Reset state: all sync flops 0, prescaler 0, every FSM in IDLE, all counters and long_done flags 0, all outputs 0.
  - Reset asserted mid-operation clears everything immediately; no release pulse is emitted.
- Synchronizer: btn_i[i] -> s1 -> s2 -> s[i]. This gives 3 clk of latency before the FSM sees a change.
- Prescaler:
  - Counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for exactly one cycle when the counter equals TICK_DIV-1.
  - Free-running; shared by all channels.
- Per-channel FSM (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT). Counters per channel: db_cnt (width clog2(DB_TICKS+1)), hold_cnt (width clog2(LONG_TICKS+1)), long_done flag.
  - IDLE: s=1 -> PRESS_WAIT, db_cnt=0.
  - PRESS_WAIT:
    - s=0 -> IDLE; glitch rejected, no outputs.
    - Otherwise db_cnt increments on each tick.
    - On the tick where db_cnt==DB_TICKS-1 -> PRESSED, hold_cnt=0, long_done=0.
  - PRESSED:
    - s=0 -> RELEASE_WAIT, db_cnt=0.
    - Otherwise, while long_done=0, hold_cnt increments on each tick.
    - On the tick where hold_cnt==LONG_TICKS-1: long_done=1, and long_o fires.
  - RELEASE_WAIT:
    - s=1 -> PRESSED; a bounce is absorbed, with hold_cnt and long_done preserved (hold_cnt frozen while in RELEASE_WAIT).
    - Otherwise db_cnt increments on each tick.
    - On the tick where db_cnt==DB_TICKS-1 -> IDLE.
- Outputs:
  - All outputs are registered and update on the same edge as the causing transition.
  - level_o=1 in PRESSED and RELEASE_WAIT, 0 otherwise.
  - press_o pulses on PRESS_WAIT->PRESSED.
  - release_o pulses on RELEASE_WAIT->IDLE.
  - long_o pulses as described in PRESSED; at most one long pulse per press.
- Simultaneous events: if s changes in the same cycle as a qualifying tick, the s change wins (no acceptance). Channels are fully independent; several channels may pulse in the same cycle.
- Button held high through reset release: handled as a normal press, giving press_o after debounce.
- Counters saturate by construction and never wrap.

Decomposition:
- Package btn_pkg: btn_state_t enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT); helper localparams for counter widths.
- Sub-module debounce_channel: one FSM plus counters; inputs s and tick; outputs level, press, release, long. Instantiated N_BTN times with generate.
- Prescaler and sync flops stay in the top.

Test Plan (TICK_DIV=4, DB_TICKS=3, LONG_TICKS=5, N_BTN=4):
1. Reset:
   - rst=0 with btn_i=4'hF -> all outputs 0 and held during reset.
   - Release rst with btn_i=0 for 100 cycles -> outputs stay 0.
2. Clean press and release:
   - btn_i[0]=1 held -> press_o[0] is a single 1-cycle pulse and level_o[0]=1 within 3+12+4 cycles; no activity on channels 1-3.
   - Then btn_i[0]=0 -> release_o[0] pulse, level_o[0]=0.
3. Glitch rejection: btn_i[1]=1 for 6 cycles then 0 -> no pulses; level_o[1] stays 0.
4. Long press:
   - Hold btn_i[2] for 80 cycles -> press_o pulse, then exactly one long_o[2] pulse 5 ticks (~20 cycles) later; no further long pulses.
   - Release -> release_o[2] pulse.
5. Release bounce: in PRESSED, drop btn_i[0] for 3 cycles then restore -> no release_o; level_o[0] stays 1; long_o still fires once at the original hold point plus the frozen interval.
6. Concurrency and reset mid-press:
   - Press ch0 and ch3 in the same cycle -> press_o=4'b1001 in one cycle.
   - Assert rst while both are pressed -> level_o=0 immediately with no release pulse.
